// File: rtl/_div32_seq_pkg.sv
// Shared operation codes, FSM states and arithmetic helpers for the _div32_seq restoring divider.
package _div32_seq_pkg;

    localparam int unsigned DIV_ITERS = 32;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX
    } state_e;

    // One 74x283 slice: 4-bit sum plus carry-out in bit 4.
    function automatic logic [4:0] adder4(input logic [3:0] x, input logic [3:0] y, input logic cin);
        return {1'b0, x} + {1'b0, y} + {4'b0000, cin};
    endfunction

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    function automatic logic is_signed_op(input logic [1:0] op);
        return !((op == OP_DIVU) || (op == OP_REMU));
    endfunction

    function automatic logic is_rem_op(input logic [1:0] op);
        return !((op == OP_DIV) || (op == OP_DIVU));
    endfunction

endpackage

// File: rtl/_div32_seq_sub33.sv
// 33-bit subtractor x - y built from chained 74x283 slices (y inverted, carry-in 1).
module _sub33
    import _div32_seq_pkg::*;
(
    input  logic [32:0] x,
    input  logic [32:0] y,
    output logic [31:0] diff,
    output logic        no_borrow
);

    logic       carry;
    logic [4:0] slice_sum;

    // Bit 32 never needs storing, so only its carry-out is formed.
    always_comb begin
        carry     = 1'b1;
        slice_sum = '0;
        diff      = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            slice_sum        = adder4(x[4*i +: 4], ~y[4*i +: 4], carry);
            diff[4*i +: 4]   = slice_sum[3:0];
            carry            = slice_sum[4];
        end
        no_borrow = (x[32] & ~y[32]) | (x[32] & carry) | (~y[32] & carry);
    end

endmodule

// File: rtl/_div32_seq.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per clock.
// Optional DIV32_FASTPATH_EN: divide-by-zero and signed overflow finish in the start cycle.
module _div32_seq
    import _div32_seq_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ITER_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [ITER_W-1:0] CNT_LAST = ITER_W'(DIV_ITERS - 1);

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [XLEN-1:0]   q_q, q_d;
    logic [XLEN-1:0]   r_q, r_d;
    logic [XLEN-1:0]   bmag_q, bmag_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic              q_neg_q, q_neg_d;
    logic              r_neg_q, r_neg_d;
    logic              div0_q, div0_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              signed_op;
    logic [XLEN-1:0]   sel_val;
    logic              sel_neg;
    logic [32:0]       sub_x, sub_y;
    logic [31:0]       sub_diff;
    logic              sub_nb;

    _sub33 u_sub33 (
        .x         (sub_x),
        .y         (sub_y),
        .diff      (sub_diff),
        .no_borrow (sub_nb)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        q_d       = q_q;
        r_d       = r_q;
        bmag_d    = bmag_q;
        cnt_d     = cnt_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        div0_d    = div0_q;
        done_d    = 1'b0;
        result_d  = result_q;
        signed_op = is_signed_op(op);
        sel_val   = '0;
        sel_neg   = 1'b0;
        sub_x     = '0;
        sub_y     = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = op;
                    q_d     = signed_op ? abs32(a) : a;
                    bmag_d  = signed_op ? abs32(b) : b;
                    r_d     = '0;
                    cnt_d   = '0;
                    q_neg_d = signed_op & (a[31] ^ b[31]);
                    r_neg_d = signed_op & a[31];
                    div0_d  = (b == '0);
`ifdef DIV32_FASTPATH_EN
                    if (b == '0) begin
                        done_d   = 1'b1;
                        result_d = is_rem_op(op) ? a : '1;
                    end else if (signed_op && (a == 32'h8000_0000) && (b == '1)) begin
                        done_d   = 1'b1;
                        result_d = is_rem_op(op) ? '0 : 32'h8000_0000;
                    end else begin
                        state_d = ST_CALC;
                    end
`else
                    state_d = ST_CALC;
`endif
                end
            end

            ST_CALC: begin
                // Trial subtract of the shifted partial remainder; restore on borrow.
                sub_x = {r_q, q_q[XLEN-1]};
                sub_y = {1'b0, bmag_q};
                r_d   = sub_nb ? sub_diff : {r_q[XLEN-2:0], q_q[XLEN-1]};
                q_d   = {q_q[XLEN-2:0], sub_nb};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIX;
                end
            end

            ST_FIX: begin
                // Subtractor computes 0 - value to negate whichever result is selected.
                sel_val = is_rem_op(op_q) ? r_q : q_q;
                sel_neg = is_rem_op(op_q) ? r_neg_q : q_neg_q;
                sub_x   = '0;
                sub_y   = {1'b0, sel_val};
                if (div0_q && !is_rem_op(op_q)) begin
                    result_d = '1;
                end else begin
                    result_d = sel_neg ? sub_diff : sel_val;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            q_q      <= '0;
            r_q      <= '0;
            bmag_q   <= '0;
            cnt_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            div0_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            q_q      <= q_d;
            r_q      <= r_d;
            bmag_q   <= bmag_d;
            cnt_q    <= cnt_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            div0_q   <= div0_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign result = result_q;

endmodule
